// File: rtl/pwm_pkg.sv
// Shared types and defaults for the PWM fade sequencer.
// Imported by the fade controller top.
package pwm_pkg;

  localparam int DUTY_W_DEF = 8;

  typedef enum logic {
    IDLE,
    RAMP
  } fade_state_t;

endpackage

// File: rtl/pwm_fade_controller_tick.sv
// Fade tick prescaler: free-running divider plus a sticky
// tick flag that survives until a step consumes it.
module fade_tick_gen #(
  parameter int TICK_DIV = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_pending,
  output logic tick_pending
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] cnt;
  logic          pend_q;
  logic          tc;

  assign tc = (cnt == CW'(TICK_DIV - 1));

  // Divider counts 0..TICK_DIV-1 and wraps at terminal count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (tc) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Ticks do not accumulate; a commit consumes the pending one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= 1'b0;
    end else if (clr_pending) begin
      pend_q <= 1'b0;
    end else if (tc) begin
      pend_q <= 1'b1;
    end
  end

  assign tick_pending = pend_q | tc;

endmodule

// File: rtl/pwm_fade_controller.sv
// Ramps the PWM duty toward a target, committing changes only
// on PWM period boundaries; bypass applies target directly.
module pwm_fade_controller
  import pwm_pkg::*;
#(
  parameter int DUTY_W   = DUTY_W_DEF,
  parameter int TICK_DIV = 1000,
  parameter int STEP     = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DUTY_W-1:0] target_duty,
  input  logic              fade_en,
  input  logic              period_start,
  output logic [DUTY_W-1:0] duty_out,
  output logic              busy,
  output logic              done
);

  localparam logic [DUTY_W:0] STEP_V = (DUTY_W + 1)'(STEP);

  fade_state_t       state;
  logic              tick;
  logic              commit;
  logic [DUTY_W:0]   tgt_x;
  logic [DUTY_W:0]   duty_x;
  logic [DUTY_W:0]   mag;
  logic [DUTY_W:0]   nxt_x;
  logic [DUTY_W-1:0] nxt;

  fade_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr_pending  (commit),
    .tick_pending (tick)
  );

  assign commit = fade_en && (state == RAMP) &&
                  (duty_out != target_duty) &&
                  tick && period_start;

  // Next ramp value: one STEP toward target, snapping when close
  always_comb begin
    tgt_x  = {1'b0, target_duty};
    duty_x = {1'b0, duty_out};
    mag    = '0;
    nxt_x  = duty_x;
    if (tgt_x >= duty_x) begin
      mag   = tgt_x - duty_x;
      nxt_x = (mag <= STEP_V) ? tgt_x : duty_x + STEP_V;
    end else begin
      mag   = duty_x - tgt_x;
      nxt_x = (mag <= STEP_V) ? tgt_x : duty_x - STEP_V;
    end
    nxt = nxt_x[DUTY_W] ? '1 : nxt_x[DUTY_W-1:0];
  end

  // Sequencer: bypass, idle compare, and period-aligned ramp steps
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      duty_out <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (!fade_en) begin
        state <= IDLE;
        busy  <= 1'b0;
        if (period_start) begin
          duty_out <= target_duty;
        end
      end else begin
        unique case (state)
          IDLE: begin
            if (duty_out != target_duty) begin
              state <= RAMP;
              busy  <= 1'b1;
            end
          end
          RAMP: begin
            if (duty_out == target_duty) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else if (commit) begin
              duty_out <= nxt;
              if (nxt == target_duty) begin
                state <= IDLE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
